// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: frame position tracking, butterfly
// mode, delay-line shift enable, twiddle addressing and end-of-frame drain.
module sdf_stage_ctrl #(
    parameter int N     = 32,
    parameter int DELAY = 4,
    localparam int CNT_W   = $clog2(N),
    localparam int TW_W    = (CNT_W > 1) ? CNT_W - 1 : 1,
    localparam int TW_STEP = N / (2 * DELAY)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            sr_en,
    output logic            bf_mode,
    output logic            tw_en,
    output logic [TW_W-1:0] tw_addr,
    output logic            out_valid,
    output logic            out_last,
    output logic            busy
);

    localparam int DC_W = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int HB   = $clog2(DELAY);
    localparam int SH   = $clog2(TW_STEP);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;
    logic [DC_W-1:0]   dcnt_q, dcnt_d;
    logic              have_prev_q, have_prev_d;

    logic              accept;
    logic              half;
    logic              pos_last;
    logic              frame_end;
    logic              dcnt_last;
    logic              prev;
    logic [DC_W-1:0]   tw_idx;

    // Only the first drain cycle may take the next frame's sample 0.
    assign in_ready  = (state_q != DRAIN) | (dcnt_q == '0);
    assign accept    = in_valid & in_ready;
    assign half      = fcnt_q[HB];
    assign pos_last  = &fcnt_q[HB:0];
    assign frame_end = (fcnt_q == CNT_W'(N - 1));
    assign dcnt_last = (dcnt_q == DC_W'(DELAY - 1));
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            dcnt_q      <= '0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            dcnt_q      <= dcnt_d;
            have_prev_q <= have_prev_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        dcnt_d      = dcnt_q;
        have_prev_d = have_prev_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = RUN;
                    fcnt_d      = CNT_W'(1);
                    have_prev_d = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (pos_last) have_prev_d = 1'b1;
                    if (frame_end) begin
                        fcnt_d  = '0;
                        dcnt_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        fcnt_d = fcnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept) begin
                    // Back-to-back frame: remaining drain differences are
                    // emitted by the new frame's first half.
                    state_d     = RUN;
                    fcnt_d      = CNT_W'(1);
                    dcnt_d      = '0;
                    have_prev_d = 1'b1;
                end else if (dcnt_last) begin
                    state_d     = IDLE;
                    dcnt_d      = '0;
                    have_prev_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + DC_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                fcnt_d      = '0;
                dcnt_d      = '0;
                have_prev_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        sr_en     = 1'b0;
        bf_mode   = 1'b0;
        tw_en     = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        prev      = 1'b0;
        tw_idx    = '0;
        case (state_q)
            IDLE, RUN: begin
                prev      = (state_q == RUN) & have_prev_q;
                sr_en     = accept;
                bf_mode   = half;
                out_valid = accept & (half | prev);
                tw_en     = out_valid & ~half;
                tw_idx    = fcnt_q[DC_W-1:0];
                out_last  = accept & prev & (fcnt_q == CNT_W'(DELAY - 1));
            end
            DRAIN: begin
                sr_en     = 1'b1;
                out_valid = 1'b1;
                tw_en     = 1'b1;
                tw_idx    = dcnt_q;
                out_last  = dcnt_last;
            end
            default: ;
        endcase
        tw_addr = tw_en ? (TW_W'(tw_idx) << SH) : '0;
    end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Randomized bench for sdf_stage_ctrl: two instances (N=32/DELAY=4, N=8/DELAY=1)
// checked cycle by cycle against a queue-of-pending-differences model.
module tb_sdf_stage_ctrl;

    localparam int N0 = 32, D0 = 4, N1 = 8, D1 = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] vin = '0;

    logic ir0, sr0, bf0, te0, ov0, ol0, bz0;
    logic ir1, sr1, bf1, te1, ov1, ol1, bz1;
    logic [3:0] tw0;
    logic [1:0] tw1;

    always #5 clk = ~clk;

    sdf_stage_ctrl #(.N(N0), .DELAY(D0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(vin[0]), .in_ready(ir0), .sr_en(sr0),
        .bf_mode(bf0), .tw_en(te0), .tw_addr(tw0), .out_valid(ov0),
        .out_last(ol0), .busy(bz0)
    );

    sdf_stage_ctrl #(.N(N1), .DELAY(D1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(vin[1]), .in_ready(ir1), .sr_en(sr1),
        .bf_mode(bf1), .tw_en(te1), .tw_addr(tw1), .out_valid(ov1),
        .out_last(ol1), .busy(bz1)
    );

    wire [15:0] obs0 = {ir0, sr0, bf0, te0, ov0, ol0, bz0, 1'b0, 4'b0, tw0};
    wire [15:0] obs1 = {ir1, sr1, bf1, te1, ov1, ol1, bz1, 1'b0, 6'b0, tw1};

    int n_cmp = 0;
    int n_err = 0;
    int outs0 = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: each second-half sample queues a difference (twiddle index, is-last-of-frame);
    // first-half samples and drain cycles pop one.
    int idx[2];
    int qtw[2][16];
    bit qlast[2][16];
    int qh[2];
    int qn[2];

    function automatic int nn(input int u); return (u == 0) ? N0 : N1; endfunction
    function automatic int dd(input int u); return (u == 0) ? D0 : D1; endfunction

    function automatic void model_clear();
        for (int u = 0; u < 2; u++) begin
            idx[u] = 0; qh[u] = 0; qn[u] = 0;
        end
    endfunction

    function automatic logic [15:0] model_out(input int u, input bit v);
        int d = dd(u);
        int pos;
        bit ir = 0, sr = 0, bf = 0, te = 0, ov = 0, ol = 0, bz = 0;
        int tw = 0;
        if (idx[u] == nn(u)) begin
            ir = (qn[u] == d); sr = 1; ov = 1; te = 1; bz = 1;
            tw = qtw[u][qh[u]]; ol = qlast[u][qh[u]];
        end else begin
            pos = idx[u] % (2 * d);
            ir = 1; bf = (pos >= d); sr = v;
            bz = (idx[u] != 0) || (qn[u] != 0);
            if (v && pos < d && qn[u] > 0) begin
                ov = 1; te = 1; tw = qtw[u][qh[u]]; ol = qlast[u][qh[u]];
            end
            if (v && pos >= d) ov = 1;
        end
        return {ir, sr, bf, te, ov, ol, bz, 1'b0, 8'(tw)};
    endfunction

    function automatic void model_adv(input int u, input bit v);
        int d = dd(u);
        int n = nn(u);
        int pos;
        bit acc = v && ((idx[u] != n) || (qn[u] == d));
        if (idx[u] == n) begin
            qh[u] = (qh[u] + 1) % 16; qn[u]--;
            if (acc) idx[u] = 1;
            else if (qn[u] == 0) idx[u] = 0;
        end else if (acc) begin
            pos = idx[u] % (2 * d);
            if (pos < d) begin
                if (qn[u] > 0) begin qh[u] = (qh[u] + 1) % 16; qn[u]--; end
            end else begin
                qtw[u][(qh[u] + qn[u]) % 16]   = (pos - d) * (n / (2 * d));
                qlast[u][(qh[u] + qn[u]) % 16] = (idx[u] == n - 1);
                qn[u]++;
            end
            idx[u]++;
        end
    endfunction

    task automatic step(input bit v0, input bit v1);
        vin = {v1, v0};
        @(negedge clk);
        chk("u0_outputs", obs0, model_out(0, v0));
        chk("u1_outputs", obs1, model_out(1, v1));
        if (ov0) outs0++;
        model_adv(0, v0);
        model_adv(1, v1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        vin = '0;
        model_clear();
        #1;
        chk({tag, "_u0"}, obs0, 16'h8000);
        chk({tag, "_u1"}, obs1, 16'h8000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int cnt, input bit v);
        for (int i = 0; i < cnt; i++) step(v, v);
    endtask

    initial begin
        int pct;
        bit r0, r1;
        model_clear();
        #2;
        chk("por_u0", obs0, 16'h8000);
        chk("por_u1", obs1, 16'h8000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // single frame then drain
        outs0 = 0;
        run(32, 1'b1);
        run(6, 1'b0);
        chk("frame_out_count", 16'(outs0), 16'd32);

        // two back-to-back frames
        outs0 = 0;
        run(64, 1'b1);
        run(6, 1'b0);
        chk("b2b_out_count", 16'(outs0), 16'd64);

        // stall after sample 10
        run(11, 1'b1);
        run(3, 1'b0);
        run(21, 1'b1);
        run(6, 1'b0);

        // reset two cycles into drain, then a fresh frame
        run(32, 1'b1);
        run(2, 1'b0);
        do_reset("rst_in_drain");
        outs0 = 0;
        run(32, 1'b1);
        run(6, 1'b0);
        chk("post_rst_out_count", 16'(outs0), 16'd32);

        // random valid at varying densities, with a mid-stream reset
        for (int i = 0; i < 900; i++) begin
            pct = (i / 100) % 4 == 0 ? 95 : (i / 100) % 4 == 1 ? 60 :
                  (i / 100) % 4 == 2 ? 100 : 25;
            r0 = ($urandom_range(0, 99) < pct);
            r1 = ($urandom_range(0, 99) < pct);
            if (i == 437) do_reset("rst_mid_stream");
            step(r0, r1);
        end
        run(8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
